// File: rtl/saph_col_unpack.sv
// Streaming colour unpacker: splits 32-bit words into 1..32-bit pixels and
// decodes each one into an 8:8:8:8 colour, one pixel per cycle.
package saph_col_unpack_pkg;
  typedef enum logic [2:0] {
    PF_ARGB = 3'd0,
    PF_RGB  = 3'd1,
    PF_GREY = 3'd2,
    PF_PAL  = 3'd3,
    PF_NONE = 3'd4
  } pixcat_e;

  typedef struct packed {
    logic [4:0] pos;
    logic [2:0] width;   // channel bits minus one
  } chan_t;

  typedef struct packed {
    pixcat_e cat;
    chan_t   a;
    chan_t   r;
    chan_t   g;
    chan_t   b;
  } pixfmt_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;
endpackage

module saph_col_unpack
  import saph_col_unpack_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_first,
  input  logic [4:0]  in_lastidx,
  input  logic        in_last,
  input  pixfmt_t     format,
  input  logic [2:0]  bpp_log2,
  output logic        out_valid,
  input  logic        out_ready,
  output color_t      out_color,
  output logic        out_last
);

  // Left-align the w-bit field, then OR in right-shifted copies so the
  // field repeats MSB-first down to bit 0.
  function automatic logic [7:0] expand(input logic [31:0] p, input chan_t c);
    logic [7:0] v;
    logic [7:0] t;
    logic [7:0] r;
    int         w;
    w = int'(c.width) + 1;
    v = 8'(p >> c.pos) & 8'((9'd1 << w) - 9'd1);
    t = 8'(v << (8 - w));
    r = 8'd0;
    for (int k = 0; k < 8; k++) begin
      r = r | (t >> (k * w));
    end
    return r;
  endfunction

  logic        wvalid_q, wvalid_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  color_t      out_color_q, out_color_d;
  logic [31:0] word_q, word_d;
  pixfmt_t     fmt_q, fmt_d;
  logic [2:0]  bpp_q, bpp_d;
  logic [4:0]  end_q, end_d;
  logic        last_q, last_d;

  logic        adv, at_end, accept, empty;
  logic [2:0]  bl_in;
  logic [4:0]  ppw_m1, last_clamp;
  logic [5:0]  bpp_bits, sh_lsb, sh;
  logic [32:0] mask33;
  logic [31:0] pix;
  logic [7:0]  grey;
  color_t      col;

  // Input side: bpp codes above 5 all mean 32; the end index is clamped to the word.
  always_comb begin
    bl_in      = (bpp_log2 > 3'd5) ? 3'd5 : bpp_log2;
    ppw_m1     = 5'((6'd32 >> bl_in) - 6'd1);
    last_clamp = (in_lastidx > ppw_m1) ? ppw_m1 : in_lastidx;
    empty      = in_first > last_clamp;
    adv        = !out_valid_q || out_ready;
    at_end     = idx_q == end_q;
    in_ready   = !clear && (!wvalid_q || (adv && at_end));
    accept     = in_valid && in_ready;
  end

  always_comb begin
    bpp_bits = 6'd1 << bpp_q;
    sh_lsb   = 6'(idx_q) << bpp_q;
    sh       = MSB_FIRST ? (6'd32 - bpp_bits - sh_lsb) : sh_lsb;
    mask33   = (33'd1 << bpp_bits) - 33'd1;
    pix      = (word_q >> sh) & mask33[31:0];
    grey     = expand(pix, fmt_q.b);
    col      = '0;
    case (fmt_q.cat)
      PF_ARGB: col = '{a: expand(pix, fmt_q.a), r: expand(pix, fmt_q.r),
                       g: expand(pix, fmt_q.g), b: expand(pix, fmt_q.b)};
      PF_RGB:  col = '{a: 8'hFF, r: expand(pix, fmt_q.r),
                       g: expand(pix, fmt_q.g), b: expand(pix, fmt_q.b)};
      PF_GREY: col = '{a: 8'hFF, r: grey, g: grey, b: grey};
      PF_PAL:  col = color_t'(pix);
      default: col = '0;
    endcase
  end

  always_comb begin
    wvalid_d    = wvalid_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_color_d = out_color_q;
    word_d      = word_q;
    fmt_d       = fmt_q;
    bpp_d       = bpp_q;
    end_d       = end_q;
    last_d      = last_q;
    if (clear) begin
      wvalid_d    = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (adv) begin
        out_valid_d = wvalid_q;
        if (wvalid_q) begin
          out_color_d = col;
          out_last_d  = last_q && at_end;
          if (at_end) wvalid_d = 1'b0;
          else        idx_d    = 5'(idx_q + 5'd1);
        end
      end
      // A new word may land on the same edge the previous word's last pixel leaves.
      if (accept) begin
        wvalid_d = !empty;
        idx_d    = in_first;
        word_d   = in_data;
        fmt_d    = format;
        bpp_d    = bl_in;
        end_d    = last_clamp;
        last_d   = in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvalid_q    <= 1'b0;
      idx_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_color_q <= '0;
    end else begin
      wvalid_q    <= wvalid_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_color_q <= out_color_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    fmt_q  <= fmt_d;
    bpp_q  <= bpp_d;
    end_q  <= end_d;
    last_q <= last_d;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_color = out_color_q;

endmodule
